proc_sequencer: RTL and testbench

//  Program feeder that sits on the DIN/Run/Done side of the 4-register, 6-bit proc core.

---
 rtl/proc_sequencer_pkg.sv | 17 +
 rtl/proc_sequencer_ram.sv | 28 ++
 rtl/proc_sequencer.sv | 133 +++++++++++++
 tb/tb_proc_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_sequencer_pkg.sv
// rtl/proc_sequencer_pkg.sv - opcode fields and FSM states shared by the proc program feeder
package proc_sequencer_pkg;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH,
        ERR
    } state_t;

endpackage

// File: rtl/proc_sequencer_ram.sv
// rtl/proc_sequencer_ram.sv - program memory, synchronous write and two asynchronous read ports
module prog_ram #(
    parameter int DATAWIDTH = 6,
    parameter int ADDR_W    = 4
) (
    input  logic                 Clock,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr_a,
    output logic [DATAWIDTH-1:0] rdata_a,
    input  logic [ADDR_W-1:0]    raddr_b,
    output logic [DATAWIDTH-1:0] rdata_b
);

    logic [DATAWIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge Clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Port a carries the opcode at pc, port b the mvi immediate at pc+1.
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/proc_sequencer.sv
// rtl/proc_sequencer.sv - streams a stored program into the proc core over DIN/Run/Done
module proc_sequencer
    import proc_sequencer_pkg::*;
#(
    parameter int DATAWIDTH = 6,
    parameter int ADDR_W    = 4,
    parameter int WDOG      = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 ld_en,
    input  logic [ADDR_W-1:0]    ld_addr,
    input  logic [DATAWIDTH-1:0] ld_data,
    input  logic                 start,
    input  logic [ADDR_W:0]      prog_len,
    output logic [DATAWIDTH-1:0] DIN,
    output logic                 Run,
    input  logic                 Done,
    output logic                 busy,
    output logic                 finished,
    output logic                 err,
    output logic [ADDR_W:0]      pc,
    output logic [7:0]           icount
);

    localparam int WD_W = $clog2(WDOG + 1);

    state_t               state;
    logic [ADDR_W:0]      len;
    logic [WD_W-1:0]      wdog;
    logic [DATAWIDTH-1:0] op_word;
    logic [DATAWIDTH-1:0] imm_word;
    logic [ADDR_W-1:0]    imm_addr;
    logic [ADDR_W+1:0]    pc_next;
    logic                 is_mvi;
    logic                 trunc;

    assign busy     = (state == ISSUE) || (state == WAIT);
    assign imm_addr = pc[ADDR_W-1:0] + 1'b1;

    // A write arriving together with start lands before ISSUE reads it next cycle.
    prog_ram #(
        .DATAWIDTH(DATAWIDTH),
        .ADDR_W   (ADDR_W)
    ) u_ram (
        .Clock  (Clock),
        .we     (ld_en && !busy),
        .waddr  (ld_addr),
        .wdata  (ld_data),
        .raddr_a(pc[ADDR_W-1:0]),
        .rdata_a(op_word),
        .raddr_b(imm_addr),
        .rdata_b(imm_word)
    );

    assign is_mvi  = (op_word[DATAWIDTH-1 -: 2] == OP_MVI);
    assign trunc   = is_mvi && (({1'b0, pc} + (ADDR_W+2)'(1)) >= {1'b0, len});
    assign pc_next = {1'b0, pc} + (is_mvi ? (ADDR_W+2)'(2) : (ADDR_W+2)'(1));

    // Reset gates Run/DIN at once so proc never sees a stale Run while both reset.
    assign Run = !Reset && (((state == ISSUE) && !trunc) || (state == WAIT));

    always_comb begin
        DIN = '0;
        if (!Reset) begin
            case (state)
                ISSUE:   DIN = op_word;
                WAIT:    DIN = is_mvi ? imm_word : '0;
                default: DIN = '0;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            pc       <= '0;
            len      <= '0;
            wdog     <= '0;
            icount   <= '0;
            finished <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE, FINISH, ERR: begin
                    if (start) begin
                        pc     <= '0;
                        icount <= '0;
                        err    <= 1'b0;
                        len    <= prog_len;
                        if (prog_len == '0) begin
                            finished <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            finished <= 1'b0;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wdog <= '0;
                    if (trunc) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (Done) begin
                        if (icount != 8'hFF) begin
                            icount <= icount + 8'd1;
                        end
                        pc <= pc_next[ADDR_W:0];
                        if (pc_next >= {1'b0, len}) begin
                            finished <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            state <= ISSUE;
                        end
                    end else if (wdog == WD_W'(WDOG - 1)) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// tb/tb_proc_sequencer.sv - sequencer driving a behavioural 4-register proc core, gap scoreboard
module tb_proc_sequencer;
    import proc_sequencer_pkg::*;

    localparam int DW = 6;
    localparam int AW = 4;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          start = 1'b0;
    logic [AW:0]   prog_len = '0;
    logic [DW-1:0] DIN;
    logic          Run;
    logic          Done;
    logic          busy;
    logic          finished;
    logic          err;
    logic [AW:0]   pc;
    logic [7:0]    icount;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    proc_sequencer #(.DATAWIDTH(DW), .ADDR_W(AW), .WDOG(4)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .start   (start),
        .prog_len(prog_len),
        .DIN     (DIN),
        .Run     (Run),
        .Done    (Done),
        .busy    (busy),
        .finished(finished),
        .err     (err),
        .pc      (pc),
        .icount  (icount)
    );

    // Behavioural proc core: T0 latches IR, mv/mvi end in T1, add/sub in T3.
    logic [1:0]    tstep;
    logic [DW-1:0] ir;
    logic [DW-1:0] r [4];
    logic [DW-1:0] acc_a;
    logic [DW-1:0] acc_g;
    logic          proc_done;
    logic          proc_connect = 1'b1;

    assign proc_done = ((tstep == 2'd1) && ((ir[5:4] == OP_MV) || (ir[5:4] == OP_MVI)))
                     || (tstep == 2'd3);
    assign Done = proc_connect && proc_done;

    always @(posedge Clock) begin
        if (Reset) begin
            tstep <= 2'd0;
            ir    <= '0;
            acc_a <= '0;
            acc_g <= '0;
            for (int i = 0; i < 4; i++) r[i] <= '0;
        end else begin
            case (tstep)
                2'd0: if (Run) begin ir <= DIN; tstep <= 2'd1; end
                2'd1: begin
                    if (ir[5:4] == OP_MV) begin r[ir[3:2]] <= r[ir[1:0]]; tstep <= 2'd0; end
                    else if (ir[5:4] == OP_MVI) begin r[ir[3:2]] <= DIN; tstep <= 2'd0; end
                    else begin acc_a <= r[ir[3:2]]; tstep <= 2'd2; end
                end
                2'd2: begin
                    acc_g <= (ir[5:4] == OP_ADD) ? acc_a + r[ir[1:0]] : acc_a - r[ir[1:0]];
                    tstep <= 2'd3;
                end
                default: begin r[ir[3:2]] <= acc_g; tstep <= 2'd0; end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard of ISSUE->Done gaps, popped on each observed Done.
    int exp_gap[$];
    int cyc = 0;
    int issue_cyc = 0;
    int run_hi = 0;

    always @(negedge Clock) begin
        cyc++;
        if (Run) run_hi++;
        if (Run && Done) begin
            if (exp_gap.size() == 0) check("sb_depth", exp_gap.size(), 1);
            else check("done_gap", cyc - issue_cyc, exp_gap.pop_front());
        end
        if (Run && tstep == 2'd0) issue_cyc = cyc;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic run(input logic [AW:0] len);
        prog_len = len; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && busy; i++) tick();
        check("run_timeout_busy", busy, 0);
    endtask

    task automatic load_prog1();
        load(0, 6'h10); load(1, 6'h05); load(2, 6'h14);
        load(3, 6'h03); load(4, 6'h21); load(5, 6'h08);
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        exp_gap.delete();
    endtask

    int run_before;

    initial begin
        repeat (3) tick();
        check("rst_run", Run, 0);
        check("rst_din", DIN, 0);
        check("rst_busy", busy, 0);
        check("rst_finished", finished, 0);
        check("rst_err", err, 0);
        check("rst_pc", pc, 0);
        check("rst_icount", icount, 0);
        Reset = 1'b0;
        tick();

        // Test 1: mvi, mvi, add, mv
        load_prog1();
        exp_gap = '{1, 1, 3, 1};
        run(6);
        wait_done();
        check("t1_finished", finished, 1);
        check("t1_err", err, 0);
        check("t1_icount", icount, 4);
        check("t1_pc", pc, 6);
        check("t1_r0", r[0], 8);
        check("t1_r1", r[1], 3);
        check("t1_r2", r[2], 8);
        check("t1_sb_left", exp_gap.size(), 0);

        // Test 2: sub
        load(4, 6'h31);
        exp_gap = '{1, 1, 3};
        run(5);
        wait_done();
        check("t2_r0", r[0], 2);
        check("t2_icount", icount, 3);
        check("t2_pc", pc, 5);
        check("t2_sb_left", exp_gap.size(), 0);

        // Test 3: truncated mvi
        load(0, 6'h10);
        run_before = run_hi;
        run(1);
        check("t3_issue_run", Run, 0);
        check("t3_issue_err", err, 0);
        tick();
        check("t3_err", err, 1);
        check("t3_busy", busy, 0);
        check("t3_icount", icount, 0);
        check("t3_run_seen", run_hi - run_before, 0);

        // Test 4: Done never arrives
        load_prog1();
        proc_connect = 1'b0;
        run(6);
        repeat (4) tick();
        check("t4_wait_run", Run, 1);
        check("t4_wait_err", err, 0);
        tick();
        check("t4_err", err, 1);
        check("t4_run", Run, 0);
        proc_connect = 1'b1;
        pulse_reset();

        // Test 5: reset during add, then rerun from retained memory
        exp_gap = '{1, 1, 3, 1};
        run(6);
        for (int i = 0; i < 50 && tstep != 2'd2; i++) tick();
        check("t5_reach_add", tstep, 2);
        Reset = 1'b1;
        #1;
        check("t5_run_drop", Run, 0);
        tick();
        Reset = 1'b0;
        exp_gap.delete();
        check("t5_busy", busy, 0);
        check("t5_pc", pc, 0);
        check("t5_icount", icount, 0);
        check("t5_din", DIN, 0);
        exp_gap = '{1, 1, 3, 1};
        run(6);
        wait_done();
        check("t5_r0", r[0], 8);
        check("t5_icount_rerun", icount, 4);
        check("t5_finished", finished, 1);

        // Test 6: start/ld_en while busy, len=0, load+start same cycle
        exp_gap = '{1, 1, 3, 1};
        run(6);
        check("t6_busy", busy, 1);
        start = 1'b1; prog_len = 1; ld_en = 1'b1; ld_addr = 0; ld_data = 6'h00;
        tick();
        start = 1'b0; ld_en = 1'b0;
        wait_done();
        check("t6_icount", icount, 4);
        check("t6_pc", pc, 6);
        run(1);
        tick();
        check("t6_mem_kept_err", err, 1);
        run(0);
        check("t6_len0_finished", finished, 1);
        check("t6_len0_busy", busy, 0);
        check("t6_len0_err", err, 0);
        exp_gap = '{1};
        ld_en = 1'b1; ld_addr = 0; ld_data = 6'h08; start = 1'b1; prog_len = 1;
        tick();
        ld_en = 1'b0; start = 1'b0;
        wait_done();
        check("t6_wr_first_err", err, 0);
        check("t6_wr_first_icount", icount, 1);
        check("t6_sb_left", exp_gap.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
